// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole autoplayer and its LFSR.
package mole_pkg;

  // Autoplayer FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    REACT   = 3'd2,
    PRESS   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } ap_state_t;

  // Feedback taps for x^16+x^15+x^13+x^4+1 (state bits 15, 14, 12, 3).
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  // Pattern with every mole lit.
  localparam logic [6:0] SEG_ALL_ON = 7'h7F;

  // One-hot pick of the first unlit bit at or above start (start taken mod 7),
  // wrapping around. Returns zero only if every bit of target is lit.
  function automatic logic [6:0] wrong_bit(input logic [6:0] target,
                                           input logic [2:0] start);
    logic [6:0] pick;
    logic       found;
    logic [2:0] idx;
    int         base;
    pick  = '0;
    found = 1'b0;
    base  = (start == 3'd7) ? 0 : int'(start);
    for (int k = 0; k < 7; k++) begin
      idx = 3'((base + k) % 7);
      if (!found && !target[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left every cycle out of reset.
module mole_lfsr16
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hD00D
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // Shift in the XOR of the tapped bits each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mole_autoplayer.sv
// Closed-loop player agent: watches the core's segment pattern, waits for it
// to settle plus a jittered reaction delay, presses the lit buttons, then
// releases. Optionally adds one wrong button to exercise the core's lockout.
module mole_autoplayer
  import mole_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned REACT_CYCLES   = 8,
  parameter logic [7:0]  JITTER_MASK    = 8'h07,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hD00D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] seg_n,
  input  logic       game_end,
  input  logic       err_en,
  output logic [7:0] btn,
  output logic [7:0] presses,
  output logic [7:0] errors,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] STABLE_L = 5'(STABLE_CYCLES);
  localparam logic [8:0] REACT_L  = 9'(REACT_CYCLES);
  localparam logic [7:0] HOLD_M1  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] REL_M1   = 8'(RELEASE_CYCLES - 1);

  ap_state_t   state_q, state_d;
  logic [6:0]  target_q, target_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  delay_q, delay_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  rel_q, rel_d;
  logic [7:0]  btn_q, btn_d;
  logic [7:0]  presses_q, presses_d;
  logic [7:0]  errors_q, errors_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [6:0]  pattern;
  logic        pat_valid;
  logic        pat_same;
  logic [4:0]  cnt_inc;
  logic [8:0]  react_load;
  logic        inject;

  mole_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  // Bits 12:11 of the LFSR feed nothing but the feedback itself.
  assign lfsr_unused = ^lfsr[12:11];

  // Decode the lit pattern and the values loaded on state entry.
  always_comb begin
    pattern    = ~seg_n;
    pat_valid  = |pattern;
    pat_same   = (pattern == target_q);
    cnt_inc    = {1'b0, cnt_q} + 5'd1;
    react_load = REACT_L + {1'b0, lfsr[7:0] & JITTER_MASK};
    inject     = err_en && (lfsr[15:13] == 3'b000) && (target_q != SEG_ALL_ON);
  end

  // Next-state and registered-output logic; game_end beats !enable beats FSM.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    hold_d    = hold_q;
    rel_d     = rel_q;
    btn_d     = btn_q;
    presses_d = presses_q;
    errors_d  = errors_q;

    if (game_end) begin
      state_d = DONE;
      btn_d   = '0;
    end else if (!enable) begin
      state_d = IDLE;
      btn_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          btn_d = '0;
          if (pat_valid) begin
            target_d = pattern;
            cnt_d    = 4'd1;
            state_d  = SETTLE;
          end
        end

        SETTLE: begin
          btn_d = '0;
          if (!pat_same) begin
            if (pat_valid) begin
              target_d = pattern;
              cnt_d    = 4'd1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_inc[3:0];
            if (cnt_inc >= STABLE_L) begin
              delay_d = react_load;
              state_d = REACT;
            end
          end
        end

        REACT: begin
          btn_d = '0;
          if (!pat_same) begin
            // Round moved on before we reacted: chase the new pattern.
            if (pat_valid) begin
              target_d = pattern;
              cnt_d    = 4'd1;
              state_d  = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end else if (delay_q == 9'd0) begin
            state_d   = PRESS;
            hold_d    = HOLD_M1;
            btn_d     = {1'b0, target_q};
            presses_d = (presses_q == 8'hFF) ? presses_q : presses_q + 8'd1;
            if (inject) begin
              btn_d[6:0] = target_q | wrong_bit(target_q, lfsr[10:8]);
              errors_d   = (errors_q == 8'hFF) ? errors_q : errors_q + 8'd1;
            end
          end else begin
            delay_d = delay_q - 9'd1;
          end
        end

        PRESS: begin
          // A pattern change means the hit landed or the round timed out.
          if (!pat_same || (hold_q == 8'd0)) begin
            state_d = RELEASE;
            btn_d   = '0;
            rel_d   = REL_M1;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end

        RELEASE: begin
          btn_d = '0;
          if (rel_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            rel_d = rel_q - 8'd1;
          end
        end

        DONE: begin
          btn_d   = '0;
          state_d = IDLE;
        end

        default: begin
          btn_d   = '0;
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == SETTLE) || (state_d == REACT) ||
             (state_d == PRESS)  || (state_d == RELEASE);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cnt_q     <= '0;
      delay_q   <= '0;
      hold_q    <= '0;
      rel_q     <= '0;
      btn_q     <= '0;
      presses_q <= '0;
      errors_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      hold_q    <= hold_d;
      rel_q     <= rel_d;
      btn_q     <= btn_d;
      presses_q <= presses_d;
      errors_q  <= errors_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign btn     = btn_q;
  assign presses = presses_q;
  assign errors  = errors_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
